// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SYM_GAP,
    LETTER_GAP,
    WORD_GAP,
    ERR
  } state_t;

  // Default timing, in Morse units.
  localparam int DEF_DASH_UNITS       = 3;
  localparam int DEF_LETTER_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS   = 7;

  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;  // 'a' - 'A'
  localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;

  function automatic int umax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Character handshake plus key/status outputs of the Morse keyer.
interface morse_keyer_if;
  logic [7:0] i_ASCII;
  logic       i_Valid;
  logic       o_Ready;
  logic       o_Key;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Error;

  modport master (
    output i_ASCII, i_Valid,
    input  o_Ready, o_Key, o_Busy, o_Done, o_Error
  );

  modport slave (
    input  i_ASCII, i_Valid,
    output o_Ready, o_Key, o_Busy, o_Done, o_Error
  );
endinterface

// File: rtl/morse_code_rom.sv
// Uppercase ASCII to Morse pattern lookup. pattern[0] is the first symbol
// sent, 1 = dash. Punctuation exists only when MAX_SYMBOLS is 6.
module morse_code_rom #(
  parameter int MAX_SYMBOLS = 5
) (
  input  logic [7:0]                       ascii,
  output logic [MAX_SYMBOLS-1:0]           pattern,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0] length,
  output logic                             supported
);

  // Table is written in send order (first symbol = MSB of the used bits),
  // which is how Morse is normally read; {length, code}.
  logic [8:0] ent;
  logic [5:0] code;
  logic [2:0] n;

  // Character lookup.
  always_comb begin
    ent = '0;
    case (ascii)
      "A": ent = {3'd2, 6'b01};
      "B": ent = {3'd4, 6'b1000};
      "C": ent = {3'd4, 6'b1010};
      "D": ent = {3'd3, 6'b100};
      "E": ent = {3'd1, 6'b0};
      "F": ent = {3'd4, 6'b0010};
      "G": ent = {3'd3, 6'b110};
      "H": ent = {3'd4, 6'b0000};
      "I": ent = {3'd2, 6'b00};
      "J": ent = {3'd4, 6'b0111};
      "K": ent = {3'd3, 6'b101};
      "L": ent = {3'd4, 6'b0100};
      "M": ent = {3'd2, 6'b11};
      "N": ent = {3'd2, 6'b10};
      "O": ent = {3'd3, 6'b111};
      "P": ent = {3'd4, 6'b0110};
      "Q": ent = {3'd4, 6'b1101};
      "R": ent = {3'd3, 6'b010};
      "S": ent = {3'd3, 6'b000};
      "T": ent = {3'd1, 6'b1};
      "U": ent = {3'd3, 6'b001};
      "V": ent = {3'd4, 6'b0001};
      "W": ent = {3'd3, 6'b011};
      "X": ent = {3'd4, 6'b1001};
      "Y": ent = {3'd4, 6'b1011};
      "Z": ent = {3'd4, 6'b1100};
      "0": ent = {3'd5, 6'b11111};
      "1": ent = {3'd5, 6'b01111};
      "2": ent = {3'd5, 6'b00111};
      "3": ent = {3'd5, 6'b00011};
      "4": ent = {3'd5, 6'b00001};
      "5": ent = {3'd5, 6'b00000};
      "6": ent = {3'd5, 6'b10000};
      "7": ent = {3'd5, 6'b11000};
      "8": ent = {3'd5, 6'b11100};
      "9": ent = {3'd5, 6'b11110};
      ".": if (MAX_SYMBOLS >= 6) ent = {3'd6, 6'b010101};
      ",": if (MAX_SYMBOLS >= 6) ent = {3'd6, 6'b110011};
      "?": if (MAX_SYMBOLS >= 6) ent = {3'd6, 6'b001100};
      default: ent = '0;
    endcase
  end

  assign code = ent[5:0];
  assign n    = ent[8:6];

  // Reverse the used bits so the first symbol lands in bit 0.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < MAX_SYMBOLS; i++)
      if (3'(i) < n) pattern[i] = code[n - 3'd1 - 3'(i)];
  end

  assign length    = ($clog2(MAX_SYMBOLS+1))'(n);
  assign supported = (n != 3'd0);

endmodule

// File: rtl/morse_keyer.sv
// Serial Morse transmitter: accepts ASCII over valid/ready and drives a key
// line with unit timing, symbol/letter gaps and word spacing.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int CLKS_PER_UNIT    = 2_500_000,
  parameter int MAX_SYMBOLS      = 5,
  parameter int DASH_UNITS       = DEF_DASH_UNITS,
  parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
  parameter int WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  morse_keyer_if.slave  bus
);

  localparam int CW          = $clog2(CLKS_PER_UNIT);
  // A space only adds what the preceding letter gap did not already provide.
  localparam int SPACE_UNITS = WORD_GAP_UNITS - LETTER_GAP_UNITS;
  localparam int MAX_UNITS   = umax(umax(DASH_UNITS, LETTER_GAP_UNITS), umax(SPACE_UNITS, 1));
  localparam int UW          = $clog2(MAX_UNITS + 1);
  localparam int LW          = $clog2(MAX_SYMBOLS + 1);

  state_t                 state;
  logic [CW-1:0]          unit_cnt;
  logic [UW-1:0]          units_left;   // units remaining after the current one
  logic [MAX_SYMBOLS-1:0] pat;          // bit 0 is always the current symbol
  logic [LW-1:0]          syms_left;    // symbols after the current one
  logic                   key_q, busy_q, done_q, err_q;

  logic [7:0]             ascii_up;
  logic [MAX_SYMBOLS-1:0] rom_pat;
  logic [LW-1:0]          rom_len;
  logic                   rom_ok;
  logic                   accept, unit_end, span_end;

  assign ascii_up = (bus.i_ASCII >= ASCII_LOWER_A && bus.i_ASCII <= ASCII_LOWER_Z)
                    ? bus.i_ASCII - ASCII_CASE_OFS : bus.i_ASCII;

  morse_code_rom #(.MAX_SYMBOLS(MAX_SYMBOLS)) u_rom (
    .ascii     (ascii_up),
    .pattern   (rom_pat),
    .length    (rom_len),
    .supported (rom_ok)
  );

  assign bus.o_Ready = (state == IDLE) && !i_Rst;
  assign accept      = bus.i_Valid && bus.o_Ready;
  assign unit_end    = (unit_cnt == CW'(CLKS_PER_UNIT - 1));
  assign span_end    = unit_end && (units_left == '0);

  function automatic logic [UW-1:0] mark_len(input logic dash);
    return dash ? UW'(DASH_UNITS - 1) : '0;
  endfunction

  // Keyer FSM, unit counters and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      unit_cnt   <= '0;
      units_left <= '0;
      pat        <= '0;
      syms_left  <= '0;
      key_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unit_cnt <= unit_end ? '0 : unit_cnt + 1'b1;
      if (unit_end && units_left != '0) units_left <= units_left - 1'b1;

      case (state)
        IDLE: begin
          unit_cnt <= '0;
          if (accept) begin
            busy_q <= 1'b1;
            if (ascii_up == ASCII_SPACE) begin
              state      <= WORD_GAP;
              units_left <= UW'(SPACE_UNITS - 1);
            end else if (rom_ok) begin
              state      <= MARK;
              pat        <= rom_pat;
              syms_left  <= rom_len - 1'b1;
              units_left <= mark_len(rom_pat[0]);
              key_q      <= 1'b1;
            end else begin
              state <= ERR;
              err_q <= 1'b1;
            end
          end
        end
        MARK: if (span_end) begin
          key_q <= 1'b0;
          if (syms_left != '0) begin
            state      <= SYM_GAP;
            units_left <= '0;
          end else begin
            state      <= LETTER_GAP;
            units_left <= UW'(LETTER_GAP_UNITS - 1);
          end
        end
        SYM_GAP: if (span_end) begin
          state      <= MARK;
          key_q      <= 1'b1;
          pat        <= pat >> 1;
          syms_left  <= syms_left - 1'b1;
          units_left <= mark_len(pat[1]);
        end
        LETTER_GAP, WORD_GAP: if (span_end) begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        ERR: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          unit_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Key   = key_q;
  assign bus.o_Busy  = busy_q;
  assign bus.o_Done  = done_q;
  assign bus.o_Error = err_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: two instances (5- and 6-symbol builds) driven with the
// same characters and checked every cycle against a timing model built from
// Morse strings.
module tb_morse_keyer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ascii = 8'h00;
  logic       valid = 1'b0;
  int         vecs = 0;
  int         miss = 0;

  always #5 clk = ~clk;

  morse_keyer_if bus5();
  morse_keyer_if bus6();
  assign bus5.i_ASCII = ascii;
  assign bus5.i_Valid = valid;
  assign bus6.i_ASCII = ascii;
  assign bus6.i_Valid = valid;

  morse_keyer #(.CLKS_PER_UNIT(N), .MAX_SYMBOLS(5)) dut5 (.i_Clk(clk), .i_Rst(rst), .bus(bus5.slave));
  morse_keyer #(.CLKS_PER_UNIT(N), .MAX_SYMBOLS(6)) dut6 (.i_Clk(clk), .i_Rst(rst), .bus(bus6.slave));

  // Morse text for a character: "" = unsupported, " " = word space.
  function automatic string morse_of(input logic [7:0] ch, input int ms);
    logic [7:0] c;
    c = ch;
    if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      " ": return " ";
      ".": return (ms >= 6) ? ".-.-.-" : "";
      ",": return (ms >= 6) ? "--..--" : "";
      "?": return (ms >= 6) ? "..--.." : "";
      default: return "";
    endcase
  endfunction

  // Busy cycles for a character (1 for the error cycle).
  function automatic int span(input string code);
    int u;
    if (code == "") return 1;
    if (code == " ") return 4 * N;
    u = 3;
    for (int i = 0; i < code.len(); i++) begin
      u += (code[i] == 8'h2d) ? 3 : 1;
      if (i < code.len() - 1) u += 1;
    end
    return u * N;
  endfunction

  // Expected {key,busy,done,err,ready} j cycles after the accepting edge.
  function automatic logic [4:0] exp_at(input string code, input int j);
    int l, t, m;
    l = span(code);
    if (code == "") return (j == 1) ? 5'b01010 : 5'b00001;
    if (j > l + 1) return 5'b00001;
    if (j == l + 1) return 5'b00101;
    if (code == " ") return 5'b01000;
    t = j - 1;
    for (int i = 0; i < code.len(); i++) begin
      m = ((code[i] == 8'h2d) ? 3 : 1) * N;
      if (t < m) return 5'b11000;
      t -= m;
      if (i < code.len() - 1) begin
        if (t < N) return 5'b01000;
        t -= N;
      end
    end
    return 5'b01000;
  endfunction

  task automatic chk(input string nm, input logic [4:0] e5, input logic [4:0] e6);
    logic [4:0] a5, a6;
    a5 = {bus5.o_Key, bus5.o_Busy, bus5.o_Done, bus5.o_Error, bus5.o_Ready};
    a6 = {bus6.o_Key, bus6.o_Busy, bus6.o_Done, bus6.o_Error, bus6.o_Ready};
    vecs += 2;
    if (a5 !== e5) begin
      miss++;
      $display("FAIL %s ms5: got %b want %b (key,busy,done,err,ready)", nm, a5, e5);
    end
    if (a6 !== e6) begin
      miss++;
      $display("FAIL %s ms6: got %b want %b (key,busy,done,err,ready)", nm, a6, e6);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    vecs++;
    if (got != want) begin
      miss++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b0;
      ascii = 8'($urandom);
      @(negedge clk);
      chk("idle", 5'b00001, 5'b00001);
    end
  endtask

  // Present ch (entered at a negedge with both DUTs idle), check every cycle
  // until both are idle again; return per-DUT busy/key/error cycle counts.
  task automatic send(input logic [7:0] ch, output int b5, output int k5, output int e5,
                      output int b6, output int k6, output int e6);
    string c5, c6;
    int    jmax;
    c5 = morse_of(ch, 5);
    c6 = morse_of(ch, 6);
    jmax = ((span(c5) > span(c6)) ? span(c5) : span(c6)) + 1;
    b5 = 0; k5 = 0; e5 = 0; b6 = 0; k6 = 0; e6 = 0;
    ascii = ch;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    ascii = 8'($urandom);
    for (int j = 1; j <= jmax; j++) begin
      @(negedge clk);
      chk($sformatf("chr%02h+%0d", ch, j), exp_at(c5, j), exp_at(c6, j));
      b5 += int'(bus5.o_Busy);  k5 += int'(bus5.o_Key);  e5 += int'(bus5.o_Error);
      b6 += int'(bus6.o_Busy);  k6 += int'(bus6.o_Key);  e6 += int'(bus6.o_Error);
    end
  endtask

  typedef struct {
    logic [7:0] ch;
    int b5, k5, e5, b6, k6, e6;
  } row_t;

  row_t  tab[$];
  string pool = "ETAOINSHRDLUzqxjkw0123456789 .,?!@";

  initial begin
    int b5, k5, e5, b6, k6, e6;
    logic [7:0] ch;

    // ch, {busy, key-on, error} cycles for MAX_SYMBOLS 5 then 6, N = 4
    tab.push_back('{"E", 16,  4, 0, 16,  4, 0});
    tab.push_back('{"a", 32, 16, 0, 32, 16, 0});
    tab.push_back('{"A", 32, 16, 0, 32, 16, 0});
    tab.push_back('{"0", 88, 60, 0, 88, 60, 0});
    tab.push_back('{"1", 80, 52, 0, 80, 52, 0});
    tab.push_back('{" ", 16,  0, 0, 16,  0, 0});
    tab.push_back('{"!",  1,  0, 1,  1,  0, 1});
    tab.push_back('{"T", 24, 12, 0, 24, 12, 0});
    tab.push_back('{"z", 56, 32, 0, 56, 32, 0});
    tab.push_back('{"?",  1,  0, 1, 72, 40, 0});
    tab.push_back('{".",  1,  0, 1, 80, 48, 0});
    tab.push_back('{",",  1,  0, 1, 88, 56, 0});
    tab.push_back('{"9", 80, 52, 0, 80, 52, 0});
    tab.push_back('{"@",  1,  0, 1,  1,  0, 1});

    // Valid held through reset: nothing accepted while reset is high.
    ascii = "E";
    valid = 1'b1;
    rst   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset", 5'b00000, 5'b00000);
    end
    rst = 1'b0;
    #1;
    chk("release", 5'b00001, 5'b00001);

    // Table rows run back to back; the first row picks up the held 'E'.
    foreach (tab[i]) begin
      send(tab[i].ch, b5, k5, e5, b6, k6, e6);
      chk_int($sformatf("busy5 %c", tab[i].ch), b5, tab[i].b5);
      chk_int($sformatf("key5 %c",  tab[i].ch), k5, tab[i].k5);
      chk_int($sformatf("err5 %c",  tab[i].ch), e5, tab[i].e5);
      chk_int($sformatf("busy6 %c", tab[i].ch), b6, tab[i].b6);
      chk_int($sformatf("key6 %c",  tab[i].ch), k6, tab[i].k6);
      chk_int($sformatf("err6 %c",  tab[i].ch), e6, tab[i].e6);
    end

    // Reset in the middle of a dash.
    ascii = "T";
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_dash", 5'b11000, 5'b11000);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", 5'b00000, 5'b00000);
    rst = 1'b0;
    #1;
    chk("rst_rel", 5'b00001, 5'b00001);
    idle(3);

    // Random characters with random idle spacing (0 = back to back).
    for (int it = 0; it < 40; it++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) ch = pool[$urandom_range(0, pool.len() - 1)];
      else                          ch = 8'($urandom_range(0, 127));
      send(ch, b5, k5, e5, b6, k6, e6);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/morse_keyer.md
# morse_keyer

Sequential Morse transmitter that accepts ASCII characters over a valid/ready handshake and drives a single on/off key line with standard Morse timing: dot 1 unit, dash 3, intra-character gap 1, letter gap 3, word gap 7. It is the parametrised, clocked successor to the combinational ASCII-to-Morse lookup. It sits between the character source (UART RX or message ROM) and the LED/buzzer driver, and adds unit timing, serialisation, word spacing and optional punctuation support.

## Interface
- CLKS_PER_UNIT, 2_500_000: clock cycles per Morse time unit; must be ≥ 2.
- MAX_SYMBOLS, 5: pattern width. Legal values are 5 (letters and digits) or 6 (adds '.', ',', '?').
- DASH_UNITS, 3: dash mark length in units.
- LETTER_GAP_UNITS, 3: key-off time after each character, in units.
- WORD_GAP_UNITS, 7: total key-off time between words, in units.

Ports:
- i_Clk  in  1  system clock; the only clock.
- i_Rst  in  1  reset, synchronous, active-high.
- i_ASCII  in  8  character to send.
- i_Valid  in  1  i_ASCII is valid.
- o_Ready  out  1  block can accept a character this cycle.
- o_Key  out  1  Morse key; 1 = mark (LED/tone on).
- o_Busy  out  1  a character or gap is in progress.
- o_Done  out  1  one-cycle pulse when a character or space completes.
- o_Error  out  1  one-cycle pulse when an unsupported character is dropped.

## Operation
- A transfer happens on a rising edge where i_Valid && o_Ready.
- o_Ready = (state == IDLE) && !i_Rst.
- Lowercase 'a'–'z' is folded to uppercase before lookup.
- Lookup returns a pattern[MAX_SYMBOLS-1:0] and a length (1..MAX_SYMBOLS).
  - Bit 0 is the first symbol sent.
  - A bit value of 1 means dash, 0 means dot.
- FSM states: IDLE, MARK, SYM_GAP, LETTER_GAP, WORD_GAP, ERR.
  - IDLE + accept of a valid char → MARK. Pattern and length are latched; symbol index = 0.
  - IDLE + accept of 0x20 (space) → WORD_GAP for (WORD_GAP_UNITS − LETTER_GAP_UNITS) units.
  - IDLE + accept of an unsupported char → ERR for one cycle, then IDLE. The key is never asserted.
  - MARK: o_Key = 1 for 1 unit (dot) or DASH_UNITS units (dash). Then go to SYM_GAP if symbols remain, otherwise LETTER_GAP.
  - SYM_GAP: 1 unit with key off; index increments → MARK.
  - LETTER_GAP and WORD_GAP: key off for their duration → IDLE.
- o_Busy = 1 in every state except IDLE.
- o_Error = 1 only in ERR.
- o_Done = 1 in the first IDLE cycle after LETTER_GAP or WORD_GAP. It is not asserted after ERR.
- Counting uses a unit counter (0..CLKS_PER_UNIT−1) and a unit-count down-counter, sized with $clog2. Both counters wrap and reload on every state change.
- Unsupported characters:
  - Any char other than A–Z, a–z, 0–9 and space.
  - '.', ',' and '?' when MAX_SYMBOLS = 5.

## Timing
- Reset values: o_Key 0, o_Busy 0, o_Done 0, o_Error 0, state IDLE. o_Ready is 0 while i_Rst is high and 1 on the first cycle after release.
- Reset mid-character: o_Key is 0 from the next edge, latched data is discarded, and o_Done/o_Error are not pulsed.
- Accept at edge k:
  - o_Key and o_Busy are high starting at cycle k+1.
  - Each unit is exactly CLKS_PER_UNIT cycles; there is no dead cycle between states.
- A character of U total units (marks + symbol gaps + letter gap) gives o_Busy for cycles k+1 … k+U·N, where N = CLKS_PER_UNIT.
  - o_Ready and o_Done are high at cycle k+U·N+1.
  - A new character may be accepted in that same cycle (back-to-back).
- Invalid character: o_Error is high at cycle k+1 and o_Ready returns at k+2.
- i_ASCII is sampled only on accept; changes at any other time have no effect.

## Structure
- Package morse_pkg holds:
  - the FSM state enum;
  - default timing constants (DASH_UNITS, LETTER_GAP_UNITS, WORD_GAP_UNITS);
  - ASCII constants (space, 'a'–'A' offset).
- Sub-module morse_code_rom: a combinational lookup parametrised by MAX_SYMBOLS.
  - Input: ASCII byte (uppercase).
  - Outputs: pattern, length, supported flag.
- morse_keyer contains the handshake, case folding, FSM and counters.

## Test plan
All scenarios use CLKS_PER_UNIT = 4.

- 'E' accepted at edge k → o_Key high for cycles k+1..k+4, low for k+5..k+16; o_Done and o_Ready at k+17.
- 'a' → key sequence high 4, low 4, high 12, low 12 cycles (32 total), identical to 'A'; o_Done at k+33.
- '0' (five dashes) → 22 units = 88 busy cycles; back-to-back '1' accepted at k+89 with no gap beyond the letter gap.
- ' ' → o_Key stays 0, o_Busy high for 16 cycles, o_Done at k+17.
- Unsupported characters:
  - '!' → o_Error pulse at k+1, key never high, o_Ready at k+2.
  - With MAX_SYMBOLS = 6, '?' (..--..) → 6 symbols, 18 units.
- Reset and handshake:
  - i_Rst asserted mid-dash → o_Key 0 next cycle, no o_Done.
  - i_Valid held high through reset is not accepted until the cycle after release.
